order_fetch: RTL



---
 rtl/order_fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/order_fetch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/order_fetch_pkg.sv
// Shared types and constants for the order_fetch instruction-fetch stage.
package order_fetch_pkg;

  localparam logic [31:0] NOP_ORDER       = 32'h0000_0000;
  localparam logic [7:0]  BUS_ERR_IRQ_NUM = 8'hFF;
  localparam logic [31:0] FETCH_STEP      = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {addr, data} entries; flush has priority over push and pop.
module fetch_fifo
  import order_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full buffer accepts push+pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage carries no reset; validity lives entirely in the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/order_fetch.sv
// Instruction-fetch stage: bus req/ack fetch FSM, prefetch FIFO, decode output register.
// Optional bus-ack timeout enabled by defining ORDER_FETCH_BUS_TIMEOUT_EN.
module order_fetch
  import order_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
  parameter int          FIFO_DEPTH     = 2,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isStop,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        irq_req,
  input  logic [7:0]  irq_num,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [31:0] order,
  output logic [31:0] thisOrderAddress,
  output logic        this_isRunning,
  output logic        interrupt,
  output logic [7:0]  interrupt_num,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      drop_addr_q, drop_addr_d;
  logic             irq_pend_q, irq_pend_d;
  logic [7:0]       irq_num_q, irq_num_d;
  logic [31:0]      order_q, order_d;
  logic [31:0]      out_addr_q, out_addr_d;
  logic             run_q, run_d;
  logic             int_q, int_d;
  logic [7:0]       int_num_q, int_num_d;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, fifo_count_after;
  fetch_entry_t     fifo_head, push_entry;
  logic             idle_issue, room_after_push, irq_take;
  logic             timeout_hit, retry_hold;
  logic [31:0]      jump_target;

  assign jump_target = word_align(jump_addr);
  assign push_entry  = '{addr: pc_q, data: mem_data};

  // IDLE issues a request in the same cycle it sees room; reset masks it combinationally.
  assign idle_issue = (state_q == ST_IDLE) && !fifo_full && !jump_en && !retry_hold;
  assign mem_req    = (state_q == ST_REQ) || (state_q == ST_DROP) || (idle_issue && !rst);
  assign mem_addr   = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  assign fifo_pop         = !isStop && !jump_en && !irq_pend_q && !fifo_empty;
  assign irq_take         = !isStop && !jump_en && irq_pend_q;
  assign fifo_count_after = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);
  assign room_after_push  = fifo_count_after < CNT_W'(FIFO_DEPTH);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (push_entry),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef ORDER_FETCH_BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_q;
  logic       bus_err_q;

  assign timeout_hit = mem_req && !mem_ack && (tmo_cnt_q == TIMEOUT_LAST);
  assign retry_hold  = bus_err_q;
  assign bus_err     = bus_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      if (mem_req && !mem_ack && !timeout_hit) tmo_cnt_q <= tmo_cnt_q + 8'd1;
      else                                     tmo_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign retry_hold     = 1'b0;
  assign bus_err        = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (jump_en) begin
          pc_d       = jump_target;
          fifo_flush = 1'b1;
          state_d    = ST_REQ;
        end else if (idle_issue) begin
          if (mem_ack) begin
            fifo_push = 1'b1;
            pc_d      = pc_q + FETCH_STEP;
            state_d   = room_after_push ? ST_REQ : ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (jump_en) begin
          pc_d        = jump_target;
          fifo_flush  = 1'b1;
          drop_addr_d = pc_q;
          state_d     = mem_ack ? ST_REQ : ST_DROP;
        end else if (mem_ack) begin
          fifo_push = 1'b1;
          pc_d      = pc_q + FETCH_STEP;
          state_d   = room_after_push ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (jump_en) pc_d = jump_target;
        if (mem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout_hit) state_d = ST_IDLE;
  end

  always_comb begin
    irq_pend_d = irq_pend_q;
    irq_num_d  = irq_num_q;
    if (irq_take) irq_pend_d = 1'b0;
    if (timeout_hit) begin
      irq_pend_d = 1'b1;
      irq_num_d  = BUS_ERR_IRQ_NUM;
    end else if (irq_req) begin
      irq_pend_d = 1'b1;
      irq_num_d  = irq_num;
    end
  end

  // Priority on an unstalled edge: redirect bubble, then interrupt marker, then FIFO head.
  always_comb begin
    order_d    = order_q;
    out_addr_d = out_addr_q;
    run_d      = run_q;
    int_d      = int_q;
    int_num_d  = int_num_q;
    if (!isStop) begin
      order_d = NOP_ORDER;
      run_d   = 1'b0;
      int_d   = 1'b0;
      if (jump_en) begin
        order_d = NOP_ORDER;
      end else if (irq_pend_q) begin
        int_d      = 1'b1;
        int_num_d  = irq_num_q;
        out_addr_d = fifo_empty ? pc_q : fifo_head.addr;
      end else if (!fifo_empty) begin
        order_d    = fifo_head.data;
        out_addr_d = fifo_head.addr;
        run_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_ADDR;
      drop_addr_q <= RESET_ADDR;
      irq_pend_q  <= 1'b0;
      irq_num_q   <= '0;
      order_q     <= NOP_ORDER;
      out_addr_q  <= '0;
      run_q       <= 1'b0;
      int_q       <= 1'b0;
      int_num_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      irq_pend_q  <= irq_pend_d;
      irq_num_q   <= irq_num_d;
      order_q     <= order_d;
      out_addr_q  <= out_addr_d;
      run_q       <= run_d;
      int_q       <= int_d;
      int_num_q   <= int_num_d;
    end
  end

  assign order            = order_q;
  assign thisOrderAddress = out_addr_q;
  assign this_isRunning   = run_q;
  assign interrupt        = int_q;
  assign interrupt_num    = int_num_q;

endmodule
